// File: rtl/dmem_pkg.sv
// Shared address map, STATUS bit positions and reset constants for the data-memory controller.
package dmem_pkg;

  localparam logic [31:0] ADDR_GPIO_OUT  = 32'h0000_1000;
  localparam logic [31:0] ADDR_GPIO_IN   = 32'h0000_1001;
  localparam logic [31:0] ADDR_TIMER_CNT = 32'h0000_1002;
  localparam logic [31:0] ADDR_TIMER_CMP = 32'h0000_1003;
  localparam logic [31:0] ADDR_STATUS    = 32'h0000_1004;

  localparam int STAT_MATCH  = 0;
  localparam int STAT_BUSERR = 1;
  localparam int STAT_IRQ_EN = 8;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] status_word(input logic match, input logic buserr,
                                              input logic irq_en);
    logic [31:0] w;
    w = '0;
    w[STAT_MATCH]  = match;
    w[STAT_BUSERR] = buserr;
    w[STAT_IRQ_EN] = irq_en;
    return w;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with compare, sticky MATCH flag, IRQ enable and level interrupt.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        status_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        match,
  output logic        irq_en,
  output logic        irq
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      cmp    <= TIMER_CMP_RST;
      match  <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      cnt <= cnt_we ? wdata : cnt + 32'd1;
      if (cmp_we) cmp <= wdata;
      // A new match outranks a simultaneous W1C clear.
      if (cnt == cmp) match <= 1'b1;
      else if (status_we && wdata[STAT_MATCH]) match <= 1'b0;
      if (status_we) irq_en <= wdata[STAT_IRQ_EN];
    end
  end

  assign irq = match & irq_en;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM, GPIO, STATUS, and an optional timer enabled by
// defining DMEM_TIMER_EN. Handshake: a request is taken on every edge where cpu_read or
// cpu_write is high (no stall); read data appears on cpu_din after the sampling edge.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int RAM_DEPTH  = 256,
  parameter int GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_write,
  input  logic                  cpu_read,
  input  logic [31:0]           cpu_address,
  input  logic [31:0]           cpu_dout,
  output logic [31:0]           cpu_din,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [31:0]           mem [RAM_DEPTH];
  logic [GPIO_WIDTH-1:0] gpio_s1, gpio_s2;
  logic                  buserr;
  logic                  hit_ram, hit_gpo, hit_gpi, hit_cnt, hit_cmp, hit_status, mapped;
  logic                  rd_en, buserr_set;
  logic [AW-1:0]         ram_idx;
  logic [31:0]           rdata;
  logic [31:0]           timer_cnt, timer_cmp;
  logic                  match, irq_en, timer_mapped;

  assign ram_idx    = cpu_address[AW-1:0];
  assign hit_ram    = cpu_address < 32'(RAM_DEPTH);
  assign hit_gpo    = cpu_address == ADDR_GPIO_OUT;
  assign hit_gpi    = cpu_address == ADDR_GPIO_IN;
  assign hit_cnt    = timer_mapped && (cpu_address == ADDR_TIMER_CNT);
  assign hit_cmp    = timer_mapped && (cpu_address == ADDR_TIMER_CMP);
  assign hit_status = cpu_address == ADDR_STATUS;
  assign mapped     = hit_ram | hit_gpo | hit_gpi | hit_cnt | hit_cmp | hit_status;

  // A simultaneous read and write is treated as a write only.
  assign rd_en      = cpu_read & ~cpu_write;
  assign buserr_set = (cpu_read & cpu_write) | ((cpu_read | cpu_write) & ~mapped)
                    | (cpu_write & hit_gpi);

`ifdef DMEM_TIMER_EN
  assign timer_mapped = 1'b1;

  dmem_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .cnt_we    (cpu_write & hit_cnt),
    .cmp_we    (cpu_write & hit_cmp),
    .status_we (cpu_write & hit_status),
    .wdata     (cpu_dout),
    .cnt       (timer_cnt),
    .cmp       (timer_cmp),
    .match     (match),
    .irq_en    (irq_en),
    .irq       (irq)
  );
`else
  assign timer_mapped = 1'b0;
  assign timer_cnt    = '0;
  assign timer_cmp    = '0;
  assign match        = 1'b0;
  assign irq_en       = 1'b0;
  assign irq          = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit_ram)         rdata = mem[ram_idx];
    else if (hit_gpo)    rdata = 32'(gpio_out);
    else if (hit_gpi)    rdata = 32'(gpio_s2);
    else if (hit_cnt)    rdata = timer_cnt;
    else if (hit_cmp)    rdata = timer_cmp;
    else if (hit_status) rdata = status_word(match, buserr, irq_en);
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (cpu_write && hit_ram) mem[ram_idx] <= cpu_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_din  <= '0;
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
      buserr   <= 1'b0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (rd_en) cpu_din <= rdata;
      if (cpu_write && hit_gpo) gpio_out <= cpu_dout[GPIO_WIDTH-1:0];
      if (buserr_set) buserr <= 1'b1;
      else if (cpu_write && hit_status && cpu_dout[STAT_BUSERR]) buserr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table for the single-cycle map, plus hand sequences
// for reset, timer (when DMEM_TIMER_EN is defined) and GPIO synchronisation.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_write, cpu_read;
  logic [31:0] cpu_address, cpu_dout, cpu_din;
  logic [15:0] gpio_in, gpio_out;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_din;
    logic [15:0] exp_gpio;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  dmem_ctrl #(.RAM_DEPTH(256), .GPIO_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_write   (cpu_write),
    .cpu_read    (cpu_read),
    .cpu_address (cpu_address),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_write   = w;
    cpu_read    = r;
    cpu_address = a;
    cpu_dout    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        16'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h10,   32'h0,        32'hDEADBEEF, 16'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,    32'h0,        32'hDEADBEEF, 16'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h2000, 32'h0,        32'h0,        16'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h0,        16'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h1000, 32'h12345,    32'h0,        16'h2345};
    vecs[8]  = '{1'b0, 1'b1, 32'h1000, 32'h0,        32'h2345,     16'h2345};
    vecs[9]  = '{1'b1, 1'b0, 32'h1001, 32'hFFFF,     32'h2345,     16'h2345};
    vecs[10] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h2345};
    vecs[11] = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h2345};
    vecs[12] = '{1'b1, 1'b1, 32'h20,   32'h77,       32'h2,        16'h2345};
    vecs[13] = '{1'b0, 1'b1, 32'h20,   32'h0,        32'h77,       16'h2345};
    vecs[14] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h2345};
    vecs[15] = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h2345};
    vecs[16] = '{1'b1, 1'b0, 32'h2000, 32'h5,        32'h2,        16'h2345};
    vecs[17] = '{1'b1, 1'b0, 32'hFF,   32'h12345678, 32'h2,        16'h2345};
    vecs[18] = '{1'b0, 1'b1, 32'hFF,   32'h0,        32'h12345678, 16'h2345};
    vecs[19] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h2345};
    vecs[20] = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h2345};
    vecs[21] = '{1'b0, 1'b1, 32'h100,  32'h0,        32'h0,        16'h2345};
    vecs[22] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h2345};
    vecs[23] = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h2345};
    vecs[24] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h0,        16'h2345};
    vecs[25] = '{1'b0, 1'b1, 32'h1005, 32'h0,        32'h0,        16'h2345};
    vecs[26] = '{1'b0, 1'b1, 32'h1004, 32'h0,        32'h2,        16'h2345};
    vecs[27] = '{1'b1, 1'b0, 32'h1004, 32'h2,        32'h2,        16'h2345};
  end

  initial begin
    rst = 1'b0;
    cpu_write = 1'b0;
    cpu_read = 1'b0;
    cpu_address = '0;
    cpu_dout = '0;
    gpio_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din", cpu_din, 32'h0);
    chk("rst_gpio", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_din", i), cpu_din, vecs[i].exp_din);
      chk($sformatf("vec%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
    end

    // Reset pulsed in the middle of a read
    @(negedge clk);
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    cpu_address = 32'h10;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_din", cpu_din, 32'h0);
    chk("midrst_gpio", 32'(gpio_out), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
`ifdef DMEM_TIMER_EN
    cpu_write = 1'b1;
    cpu_read = 1'b0;
    cpu_address = 32'h1003;
    cpu_dout = 32'd5;
`else
    cpu_write = 1'b0;
    cpu_read = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("post_rst_din", cpu_din, 32'h0);
`ifdef DMEM_TIMER_EN
    cyc(1'b1, 1'b0, 32'h1004, 32'h100);
    cyc(1'b0, 1'b1, 32'h1002, 32'h0);
    chk("cnt_after_rst", cpu_din, 32'd2);
`else
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_din", cpu_din, 32'h0);
    cyc(1'b0, 1'b1, 32'h1002, 32'h0);
    chk("cnt_unmapped", cpu_din, 32'h0);
`endif
    cyc(1'b0, 1'b1, 32'h10, 32'h0);
    chk("ram_keep_10", cpu_din, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 32'h20, 32'h0);
    chk("ram_keep_20", cpu_din, 32'h77);
    chk("irq_before_match", 32'(irq), 32'h0);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0);
`ifdef DMEM_TIMER_EN
    chk("status_ien", cpu_din, 32'h100);
    chk("irq_at_match", 32'(irq), 32'h1);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0);
    chk("status_match", cpu_din, 32'h101);
    cyc(1'b1, 1'b0, 32'h1004, 32'h101);
    chk("irq_w1c", 32'(irq), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("irq_low%0d", i), 32'(irq), 32'h0);
    end
    cyc(1'b0, 1'b1, 32'h1003, 32'h0);
    chk("cmp_read", cpu_din, 32'd5);
    cyc(1'b1, 1'b0, 32'h1002, 32'hFFFF_FFFE);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h1002, 32'h0);
    chk("cnt_wrap", cpu_din, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("irq_wrap_low%0d", i), 32'(irq), 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk("irq_after_wrap", 32'(irq), 32'h1);
`else
    chk("status_noTimer", cpu_din, 32'h2);
    chk("irq_tied", 32'(irq), 32'h0);
    cyc(1'b1, 1'b0, 32'h1004, 32'h103);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0);
    chk("status_bits_ro", cpu_din, 32'h0);
    cyc(1'b1, 1'b0, 32'h1003, 32'h5);
    cyc(1'b0, 1'b1, 32'h1004, 32'h0);
    chk("cmp_unmapped", cpu_din, 32'h2);
    chk("irq_tied2", 32'(irq), 32'h0);
`endif

    // GPIO input passes through two synchroniser flops
    @(negedge clk);
    gpio_in = 16'hA5A5;
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    cpu_address = 32'h1001;
    @(posedge clk);
    #1;
    chk("gpio_sync_e1", cpu_din, 32'h0);
    @(posedge clk);
    #1;
    chk("gpio_sync_e2", cpu_din, 32'h0);
    @(posedge clk);
    #1;
    chk("gpio_sync_e3", cpu_din, 32'h0000A5A5);
    cyc(1'b1, 1'b0, 32'h1000, 32'h12345);
    chk("gpio_out_trunc", 32'(gpio_out), 32'h2345);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
